// File: rtl/seg_scan_4.sv
// Four-digit multiplexed 7-segment scanner. Each slot is blanked for a few cycles, then shows one digit.
// All pins are registered and follow the internal state one cycle later. Build with SEG_SCAN_LEADING_ZERO_BLANK_EN to suppress leading zeros.
module seg_scan_4 #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_N = CW'(BLANK_CYCLES);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state_q, state_d;
    logic [15:0]   shadow_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          wrap_q, wrap_d;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic [3:0]    cur_dig;
    logic [3:0]    hide;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign cur_dig = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // A digit is hidden only when it and every digit above it are zero; digit 0 is never hidden.
    always_comb begin
        hide    = 4'b0000;
        hide[3] = (shadow_q[15:12] == 4'd0);
        hide[2] = hide[3] && (shadow_q[11:8] == 4'd0);
        hide[1] = hide[2] && (shadow_q[7:4] == 4'd0);
    end
`else
    assign hide = 4'b0000;
`endif

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        an_d    = 4'b1111;
        seg_d   = 7'h7F;
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            idx_d  = idx_q + 2'd1;
            wrap_d = (idx_q == 2'd3);
        end
        state_d = (cnt_d < BLANK_N) ? BLANK : SHOW;
        if (state_q == SHOW && !hide[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(cur_dig);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BLANK;
            shadow_q   <= '0;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            wrap_q     <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'h7F;
            digit_sel  <= 2'd0;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wrap_q     <= wrap_d;
            if (load)
                shadow_q <= digits;
            an         <= an_d;
            seg        <= seg_d;
            digit_sel  <= idx_q;
            // wrap_q marks the first cycle at index 0; delaying it aligns the pulse with digit_sel.
            frame_tick <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_4.sv
// Directed bench for seg_scan_4 with SCAN_DIV=8, BLANK_CYCLES=2.
// k counts rising edges since reset release; pins after edge k reflect slot position k-1.
module tb_seg_scan_4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int k = 0;

    seg_scan_4 #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .digits(digits), .load(load),
        .an(an), .seg(seg), .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Expected {an, seg, digit_sel, frame_tick} after edge kk; glyphs[7*i +: 7] is digit i, hide[i] blanks it.
    function automatic logic [13:0] expv(input int kk, input logic [27:0] glyphs, input logic [3:0] hide);
        int p, slot, ix;
        logic [3:0] a;
        logic [6:0] s;
        logic ft;
        p    = kk - 1;
        slot = p % 8;
        ix   = (p / 8) % 4;
        ft   = (kk > 1) && (p % 32 == 0);
        a    = 4'b1111;
        s    = 7'h7F;
        if (slot >= 2 && !hide[ix]) begin
            a = ~(4'b0001 << ix);
            s = glyphs[7*ix +: 7];
        end
        expv = {a, s, 2'(ix), ft};
    endfunction

    task automatic test_reset();
        reset  = 1'b0;
        digits = 16'h1234;
        load   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({an, seg, digit_sel, frame_tick} !== {4'b1111, 7'h7F, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got an=%b seg=%h sel=%0d ft=%b want an=1111 seg=7f sel=0 ft=0",
                         i, an, seg, digit_sel, frame_tick);
            end
        end
        reset = 1'b1;
        k = 0;
    endtask

    task automatic test_scan();
        logic [13:0] e;
        for (int i = 0; i < 40; i++) begin
            tick();
            load = 1'b0;
            e = expv(k, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
            checks++;
            if ({an, seg, digit_sel, frame_tick} !== e) begin
                errors++;
                $display("FAIL scan k=%0d got an=%b seg=%h sel=%0d ft=%b want an=%b seg=%h sel=%0d ft=%b",
                         k, an, seg, digit_sel, frame_tick, e[13:10], e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_mid_slot_load();
        logic [13:0] e;
        logic [3:0]  hide9;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        hide9 = 4'b1110;
`else
        hide9 = 4'b0000;
`endif
        while (k < 68) tick();
        checks++;
        if ({an, seg} !== {4'b1110, 7'h19}) begin
            errors++;
            $display("FAIL midload_before k=%0d got an=%b seg=%h want an=1110 seg=19", k, an, seg);
        end
        digits = 16'h0009;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        checks++;
        if ({an, seg} !== {4'b1110, 7'h19}) begin
            errors++;
            $display("FAIL midload_capture k=%0d got an=%b seg=%h want an=1110 seg=19", k, an, seg);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            e = expv(k, {7'h40, 7'h40, 7'h40, 7'h10}, hide9);
            checks++;
            if ({an, seg, digit_sel, frame_tick} !== e) begin
                errors++;
                $display("FAIL midload_after k=%0d got an=%b seg=%h sel=%0d ft=%b want an=%b seg=%h sel=%0d ft=%b",
                         k, an, seg, digit_sel, frame_tick, e[13:10], e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic run_frame(input string name, input logic [15:0] d, input logic [27:0] g, input logic [3:0] h);
        logic [13:0] e;
        digits = d;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        while ((k - 1) % 32 != 0) tick();
        for (int i = 0; i < 32; i++) begin
            e = expv(k, g, h);
            checks++;
            if ({an, seg, digit_sel, frame_tick} !== e) begin
                errors++;
                $display("FAIL %s k=%0d got an=%b seg=%h sel=%0d ft=%b want an=%b seg=%h sel=%0d ft=%b",
                         name, k, an, seg, digit_sel, frame_tick, e[13:10], e[9:3], e[2:1], e[0]);
            end
            tick();
        end
    endtask

    task automatic test_invalid_code();
        run_frame("invalid", 16'hF0A5, {7'h3F, 7'h40, 7'h3F, 7'h12}, 4'b0000);
    endtask

    task automatic test_leading_zero();
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        run_frame("lzero", 16'h0040, {7'h40, 7'h40, 7'h19, 7'h40}, 4'b1100);
`else
        run_frame("lzero", 16'h0040, {7'h40, 7'h40, 7'h19, 7'h40}, 4'b0000);
`endif
    endtask

    task automatic test_async_reset();
        logic [13:0] e;
        logic [6:0]  g2;
        logic [3:0]  a2;
        logic [3:0]  hide0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        g2 = 7'h7F; a2 = 4'b1111; hide0 = 4'b1110;
`else
        g2 = 7'h40; a2 = 4'b1011; hide0 = 4'b0000;
`endif
        // Internal slot count 5 of digit 2 follows edge k with k%8==5 and (k/8)%4==2.
        while (!((k % 8 == 5) && ((k / 8) % 4 == 2))) tick();
        checks++;
        if ({an, seg, digit_sel} !== {a2, g2, 2'd2}) begin
            errors++;
            $display("FAIL arst_pre k=%0d got an=%b seg=%h sel=%0d want an=%b seg=%h sel=2",
                     k, an, seg, digit_sel, a2, g2);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({an, seg, digit_sel, frame_tick} !== {4'b1111, 7'h7F, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL arst_async got an=%b seg=%h sel=%0d ft=%b want an=1111 seg=7f sel=0 ft=0",
                     an, seg, digit_sel, frame_tick);
        end
        tick();
        reset = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            e = expv(k, {7'h40, 7'h40, 7'h40, 7'h40}, hide0);
            checks++;
            if ({an, seg, digit_sel, frame_tick} !== e) begin
                errors++;
                $display("FAIL arst_restart k=%0d got an=%b seg=%h sel=%0d ft=%b want an=%b seg=%h sel=%0d ft=%b",
                         k, an, seg, digit_sel, frame_tick, e[13:10], e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_mid_slot_load();
        test_invalid_code();
        test_leading_zero();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
